// File: rtl/psum_pkg.sv
// Shared constants, lane types and the ReLU/saturation helper for the
// partial-sum requantisation stage.
package psum_pkg;
    localparam int DW  = 32;
    localparam int DP  = 56;
    localparam int OW  = 8;
    localparam int SHW = 5;
    localparam int SW  = DW + 2;

    typedef logic signed [DW-1:0] acc_lane_t;
    typedef logic        [OW-1:0] out_lane_t;
    typedef logic signed [SW-1:0] sum_lane_t;

    // Clamp a shifted sum into the unsigned output range: negatives to 0,
    // anything above 2^OW-1 to all-ones.
    function automatic out_lane_t sat_relu(input sum_lane_t y);
        if (y[SW-1])
            return '0;
        else if (|y[SW-2:OW])
            return '1;
        else
            return y[OW-1:0];
    endfunction
endpackage

// File: rtl/psum_requant_out_lane.sv
// One lane of the requantiser: S1 adds bias and rounding constant, S2 shifts
// and clamps. Only data lives here; valids are tracked once in the top.
module requant_lane
    import psum_pkg::*;
(
    input  logic            clk,
    input  logic            s1_en,
    input  logic            s2_en,
    input  acc_lane_t       x,
    input  acc_lane_t       bias,
    input  logic [SHW-1:0]  shift,
    input  logic [SHW-1:0]  s1_shift,
    output out_lane_t       y
);
    sum_lane_t rnd;
    sum_lane_t s1_d;
    sum_lane_t s1_sum;
    sum_lane_t shifted;

    // Two guard bits keep x + bias + 2^(shift-1) from wrapping.
    always_comb begin
        rnd     = (shift == '0) ? '0 : (sum_lane_t'(1) << (shift - 1'b1));
        s1_d    = sum_lane_t'(x) + sum_lane_t'(bias) + rnd;
        shifted = s1_sum >>> s1_shift;
    end

    always_ff @(posedge clk) begin
        if (s1_en)
            s1_sum <= s1_d;
        if (s2_en)
            y <= sat_relu(shifted);
    end
endmodule

// File: rtl/psum_requant_out.sv
// Requantises one accumulated row per accept into 8-bit lanes, buffers rows in
// a small FIFO and hands them to the feature-map writer with a last-row tag.
module psum_requant_out
    import psum_pkg::*;
#(
    parameter int FIFO_DP = 4,
    parameter int ROWS    = 56
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW*DP-1:0] in_data,
    input  acc_lane_t        cfg_bias,
    input  logic [SHW-1:0]   cfg_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW*DP-1:0] out_data,
    output logic             out_last,
    output logic             overflow
);
    localparam int AW  = $clog2(FIFO_DP);
    localparam int CW  = AW + 1;
    localparam int RCW = $clog2(ROWS);

    // Handshake: a row moves when valid & ready in the same cycle; in_ready and
    // out_valid depend only on registered state, never on the partner's signal.
    logic                 s1_valid;
    logic                 s2_valid;
    logic [SHW-1:0]       s1_shift;
    out_lane_t [DP-1:0]   s2_row;
    logic [CW-1:0]        fifo_count;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [RCW-1:0]       row_cnt;
    logic [CW:0]          occupancy;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [OW*DP-1:0]     mem_data [FIFO_DP];
    logic                 mem_last [FIFO_DP];

    for (genvar i = 0; i < DP; i++) begin : g_lane
        requant_lane u_lane (
            .clk      (clk),
            .s1_en    (accept),
            .s2_en    (s1_valid),
            .x        (in_data[DW*i +: DW]),
            .bias     (cfg_bias),
            .shift    (cfg_shift),
            .s1_shift (s1_shift),
            .y        (s2_row[i])
        );
    end

    // Every row in S1/S2 already owns a FIFO slot, so the pipe never stalls.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(s1_valid) + (CW+1)'(s2_valid);
    assign in_ready  = occupancy < (CW+1)'(FIFO_DP);
    assign accept    = in_valid & in_ready;
    assign push      = s2_valid;
    assign out_valid = fifo_count != '0;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_last  = out_valid ? mem_last[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= s2_row;
            mem_last[wr_ptr] <= (row_cnt == RCW'(ROWS - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s1_shift   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            row_cnt    <= '0;
            overflow   <= 1'b0;
        end else if (clr) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s1_shift   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            row_cnt    <= '0;
            overflow   <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (accept)
                s1_shift <= cfg_shift;
            if (in_valid && !in_ready)
                overflow <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (row_cnt == RCW'(ROWS - 1))
                    row_cnt <= '0;
                else
                    row_cnt <= row_cnt + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: doc/psum_requant_out.md
Name: psum_requant_out

Overview:
- Downstream stage of the 3-channel partial-sum accumulator.
- Takes one 56-lane row of signed 32-bit accumulated sums and applies per-layer bias, rounding right-shift, ReLU and unsigned saturation to 8 bits.
- Buffers results in a small FIFO and presents them to the output feature-map writer over a valid/ready handshake.
- Tracks row position so the writer gets a last-row marker per output feature map.

Parameters:
- DW, 32, accumulator lane width (signed two's complement)
- DP, 56, lanes per row
- OW, 8, output lane width (unsigned)
- SHW, 5, shift amount width
- FIFO_DP, 4, output FIFO depth in rows (power of 2, >=2)
- ROWS, 56, rows per output feature map

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush of pipeline, FIFO, row counter and overflow flag
- in_valid  in  1  in_data holds a valid accumulated row
- in_ready  out  1  block can accept a row this cycle
- in_data  in  DW*DP  lane i at [DW*i +: DW], signed
- cfg_bias  in  DW  signed bias, added to every lane
- cfg_shift  in  SHW  arithmetic right-shift amount, 0..31
- out_valid  out  1  out_data/out_last valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_data  out  OW*DP  lane i at [OW*i +: OW], unsigned
- out_last  out  1  row is row ROWS-1 of the current map
- overflow  out  1  sticky: a row was offered while in_ready=0

Behaviour:
- Reset/clr: all pipeline valids, FIFO pointers and count, row_cnt and overflow go to 0.
  - Reset/clr outputs: out_valid=0, out_data=0, out_last=0, in_ready=1.
  - Reset mid-operation discards all in-flight rows, with no partial output.
  - clr has priority over every other event in the same cycle.
- Accept: a row is accepted when in_valid & in_ready.
  - cfg_bias and cfg_shift are sampled with the row and carried down the pipe.
  - Changing cfg between rows therefore takes effect per row.
- S1 (registered), per lane: s = sign_ext(x, DW+2) + sign_ext(bias, DW+2) + (shift>0 ? 2^(shift-1) : 0).
  - Uses DW+2 bits, so there is no intermediate overflow.
- S2 (registered), per lane: y = s >>> shift (arithmetic), then y<0 -> 0, y>2^OW-1 -> 2^OW-1, else y[OW-1:0].
  - Rounding is round-half-up: -2.5 rounds to -2, then ReLU gives 0.
- The pipeline never stalls. An S2-valid row is written into the FIFO the cycle after S2 is loaded.
  - Latency: row accepted in cycle t -> out_valid=1 in cycle t+3 when the FIFO is empty.
- Credit-based in_ready:
  - in_ready = (FIFO_DP - fifo_count - s1_valid - s2_valid) > 0, computed from registered state, so in_ready is combinational-free of in_valid.
  - This guarantees the FIFO never overflows.
  - The upstream accumulator cannot stall mid-pipe. Its controller must gate its own issue on in_ready.
  - in_valid while in_ready=0: the row is dropped and overflow is set (sticky until clr/reset).
- Output: FIFO head drives out_data/out_last directly (registered storage).
  - out_valid = fifo_count != 0.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle with count=FIFO_DP or 0 is legal: count is unchanged when both occur with count>0; a push into an empty FIFO is visible the next cycle.
  - out_data/out_last must stay stable while out_valid & !out_ready.
- Row counter:
  - out_last = (row_cnt == ROWS-1) for the head row. row_cnt is tagged at push time.
  - row_cnt increments on each FIFO push and wraps ROWS-1 -> 0.

Decomposition:
- Shared package psum_pkg:
  - DW, DP, OW, SHW constants
  - lane typedefs (acc_lane_t signed [DW-1:0], out_lane_t [OW-1:0])
  - function sat_relu (DW+2 -> OW)
- Sub-module requant_lane: one lane's S1/S2 registers and arithmetic, instantiated DP times via generate.
- The FIFO, credit logic and row counter stay in the top.

Test Plan:
- Lane0 x=1000, bias=24, shift=2, all others 0, out_ready=1 -> after 3 cycles lane0 = (1024+2)>>2 = 256 saturates to 255; other lanes = 0; out_last=0.
- x=-40, bias=10, shift=0 -> lane = 0 (ReLU). x=37, bias=0, shift=3 -> (37+4)>>3 = 5. x=36, shift=3 -> 5. x=35, shift=3 -> 4.
- Stream 56 rows back-to-back with out_ready=1 -> 56 outputs in order, out_last only on the 56th; the 57th row has out_last=0 (wrap).
- Hold out_ready=0 and offer rows continuously -> exactly 4 accepted, in_ready=0 afterwards, data stable. Release -> 4 rows in order, then in_ready returns to 1.
- Force in_valid=1 while in_ready=0 -> overflow=1 and the row is absent from the output. clr -> overflow=0, out_valid=0, row_cnt=0.
- Assert rst_n=0 with 2 rows in FIFO and 1 in S1 -> out_valid=0 immediately (async). After release, a new row appears at t+3 with out_last reflecting row_cnt=0.
